// File: rtl/score_seg_driver.sv
// score_seg_driver: saturates the running score at 9999, converts it to four
// BCD digits with a sequential double-dabble engine, and scans the digits onto
// a 4-digit common-anode 7-segment display.
module score_seg_driver #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter bit          BLANK_LZ    = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] total,
   output logic        CA,
   output logic        CB,
   output logic        CC,
   output logic        CD,
   output logic        CE,
   output logic        CF,
   output logic        CG,
   output logic [3:0]  AN,
   output logic [15:0] bcd,
   output logic        busy
);

   localparam int unsigned SAT_MAX = 9999;
   localparam int unsigned BIN_W   = 14;
   localparam int unsigned BCD_W   = 16;
   localparam int unsigned WORK_W  = BIN_W + BCD_W;
   localparam int unsigned ITER_W  = 4;
   localparam int unsigned CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [WORK_W-1:0]   work_q, work_d;
   logic [ITER_W-1:0]   iter_q, iter_d;
   logic [BCD_W-1:0]    bcd_q, bcd_d;
   logic [CNT_W-1:0]    refresh_q, refresh_d;
   logic [1:0]          digit_q, digit_d;

   logic [BIN_W-1:0]    sat_c;
   logic [WORK_W-1:0]   adj_c;
   logic [3:0]          nib_c;
   logic                blank_c;
   logic [6:0]          seg_c;
   logic [3:0]          an_c;

   // Saturating sample of the full 32-bit score.
   assign sat_c = (total > 32'(SAT_MAX)) ? BIN_W'(SAT_MAX) : total[BIN_W-1:0];

   // Conversion state, work register, iteration count and committed BCD.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         work_q  <= '0;
         iter_q  <= '0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         iter_q  <= iter_d;
         bcd_q   <= bcd_d;
      end
   end

   // Double-dabble sequencing: sample, 14 add-3/shift steps, commit.
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      iter_d  = iter_q;
      bcd_d   = bcd_q;
      adj_c   = work_q;
      case (state_q)
         S_IDLE: begin
            work_d  = {{BCD_W{1'b0}}, sat_c};
            iter_d  = '0;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            for (int n = 0; n < 4; n++) begin
               if (adj_c[BIN_W + 4*n +: 4] >= 4'd5) begin
                  adj_c[BIN_W + 4*n +: 4] = adj_c[BIN_W + 4*n +: 4] + 4'd3;
               end
            end
            work_d = {adj_c[WORK_W-2:0], 1'b0};
            iter_d = iter_q + ITER_W'(1);
            if (iter_q == ITER_W'(BIN_W - 1)) begin
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            bcd_d   = work_q[WORK_W-1:BIN_W];
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Refresh counter and digit index registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         refresh_q <= '0;
         digit_q   <= '0;
      end else begin
         refresh_q <= refresh_d;
         digit_q   <= digit_d;
      end
   end

   // Digit slot timing: advance to the next digit every REFRESH_DIV cycles.
   always_comb begin
      refresh_d = refresh_q + CNT_W'(1);
      digit_d   = digit_q;
      if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
         refresh_d = '0;
         digit_d   = digit_q + 2'd1;
      end
   end

   // Select the active digit and decide whether it is a leading zero.
   always_comb begin
      nib_c   = bcd_q[3:0];
      blank_c = 1'b0;
      case (digit_q)
         2'd0: begin
            nib_c   = bcd_q[3:0];
            blank_c = 1'b0;
         end
         2'd1: begin
            nib_c   = bcd_q[7:4];
            blank_c = BLANK_LZ && (bcd_q[15:4] == 12'h000);
         end
         2'd2: begin
            nib_c   = bcd_q[11:8];
            blank_c = BLANK_LZ && (bcd_q[15:8] == 8'h00);
         end
         default: begin
            nib_c   = bcd_q[15:12];
            blank_c = BLANK_LZ && (bcd_q[15:12] == 4'h0);
         end
      endcase
   end

   // Active-low segment and anode decode; dark while reset or blanked.
   always_comb begin
      seg_c = 7'b1111111;
      an_c  = 4'b1111;
      if (!reset && !blank_c) begin
         an_c = ~(4'b0001 << digit_q);
         case (nib_c)
            4'd0:    seg_c = 7'b0000001;
            4'd1:    seg_c = 7'b1001111;
            4'd2:    seg_c = 7'b0010010;
            4'd3:    seg_c = 7'b0000110;
            4'd4:    seg_c = 7'b1001100;
            4'd5:    seg_c = 7'b0100100;
            4'd6:    seg_c = 7'b0100000;
            4'd7:    seg_c = 7'b0001111;
            4'd8:    seg_c = 7'b0000000;
            4'd9:    seg_c = 7'b0000100;
            default: seg_c = 7'b1111111;
         endcase
      end
   end

   assign {CA, CB, CC, CD, CE, CF, CG} = seg_c;
   assign AN   = an_c;
   assign bcd  = bcd_q;
   assign busy = (state_q != S_IDLE);

endmodule
